// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter: locks one of N_REQ byte streams onto a single UART serializer.
// Defining UART_TX_ARB_WATCHDOG_EN adds a stall watchdog that aborts a stuck packet.
module uart_tx_arbiter #(
  parameter int N_REQ       = 3,
  parameter int WDOG_CYCLES = 4096,
  localparam int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*8-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               abort,
  output logic [IDX_W-1:0]   abort_id
);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_r, state_nxt_s;
  logic [IDX_W-1:0] owner_r, rr_ptr_r, pick_idx_s, cand_idx_s, next_ptr_s;
  logic [N_REQ-1:0] grant_r, pick_oh_s;
  logic             found_s, hs_s, done_s, wdog_fire_s;
  int               cand_s;

  // Round-robin search for the first valid requester at or after rr_ptr.
  always_comb begin
    pick_idx_s = {IDX_W{1'b0}};
    pick_oh_s  = {N_REQ{1'b0}};
    found_s    = 1'b0;
    cand_s     = 0;
    cand_idx_s = {IDX_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      cand_s     = int'(rr_ptr_r) + k;
      cand_idx_s = IDX_W'((cand_s >= N_REQ) ? (cand_s - N_REQ) : cand_s);
      pick_idx_s = (!found_s && req_valid[cand_idx_s]) ? cand_idx_s : pick_idx_s;
      found_s    = found_s | req_valid[cand_idx_s];
    end
    pick_oh_s[pick_idx_s] = found_s;
  end

  assign hs_s       = tx_valid & tx_ready;
  assign done_s     = hs_s & req_last[owner_r];
  assign next_ptr_s = (owner_r == IDX_W'(N_REQ - 1)) ? {IDX_W{1'b0}} : (owner_r + IDX_W'(1));

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (found_s) state_nxt_s = LOCKED;
        else         state_nxt_s = IDLE;
      end
      LOCKED: begin
        if (done_s || wdog_fire_s) state_nxt_s = IDLE;
        else                       state_nxt_s = LOCKED;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Owner's stream is passed straight through to the serializer while locked.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    req_ready = {N_REQ{1'b0}};
    if (state_r == LOCKED) begin
      tx_valid           = req_valid[owner_r];
      tx_data            = req_data[{owner_r, 3'b000} +: 8];
      req_ready[owner_r] = tx_ready;
    end else begin
      tx_valid  = 1'b0;
      req_ready = {N_REQ{1'b0}};
    end
  end

  // State, owner, grant and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      owner_r  <= {IDX_W{1'b0}};
      rr_ptr_r <= {IDX_W{1'b0}};
      grant_r  <= {N_REQ{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            owner_r <= pick_idx_s;
            grant_r <= pick_oh_s;
          end
        end
        LOCKED: begin
          if (done_s || wdog_fire_s) begin
            grant_r  <= {N_REQ{1'b0}};
            rr_ptr_r <= next_ptr_s;
          end
        end
        default: grant_r <= {N_REQ{1'b0}};
      endcase
    end
  end

  assign grant = grant_r;
  assign busy  = (state_r == LOCKED);

`ifdef UART_TX_ARB_WATCHDOG_EN
  localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  logic [WDOG_W-1:0] wdog_cnt_r;
  logic              abort_r;
  logic [IDX_W-1:0]  abort_id_r;

  assign wdog_fire_s = (state_r == LOCKED) && !hs_s &&
                       (wdog_cnt_r == WDOG_W'(WDOG_CYCLES - 1));

  // Stall counter; abort is a registered one-cycle pulse following the firing cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt_r <= {WDOG_W{1'b0}};
      abort_r    <= 1'b0;
      abort_id_r <= {IDX_W{1'b0}};
    end else begin
      abort_r <= wdog_fire_s;
      if (wdog_fire_s) abort_id_r <= owner_r;
      if ((state_r != LOCKED) || hs_s || wdog_fire_s) wdog_cnt_r <= {WDOG_W{1'b0}};
      else                                            wdog_cnt_r <= wdog_cnt_r + WDOG_W'(1);
    end
  end

  assign abort    = abort_r;
  assign abort_id = abort_id_r;
`else
  logic wdog_unused_s;
  assign wdog_unused_s = (WDOG_CYCLES > 32'sd0);
  assign wdog_fire_s   = 1'b0;
  assign abort         = 1'b0;
  assign abort_id      = {IDX_W{1'b0}};
`endif

endmodule
